// File: rtl/bus_arbiter.sv
// Purpose: round-robin two-master arbiter for the single-outstanding peripheral bus, with hung-slave timeout.
// Latency: grant registered one edge after request; completion strobe is combinational with s_ready.
// Backpressure: a master holds its request until its ready strobe; a stalled slave is cut off after TIMEOUT_CYCLES.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   m0_*/m1_*                     master request (valid/write/addr/wdata) and completion (ready/rdata)
//   s_*                           request to and completion from the slave/bridge
//   gnt                           one-hot registered grant (bit0 = m0, bit1 = m1, 00 = idle)
//   err_pulse, err_addr           timeout completion strobe and address of the last timed-out transaction
module bus_arbiter #(
   parameter int          TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_valid,
   input  logic        m0_write,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_ready,
   input  logic        m1_valid,
   input  logic        m1_write,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_ready,
   output logic        s_valid,
   output logic        s_write,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   input  logic        s_ready,
   output logic [1:0]  gnt,
   output logic        err_pulse,
   output logic [31:0] err_addr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_t;

   // Counter only needs to reach TIMEOUT_CYCLES-1; keep at least one bit when the timeout is tiny or disabled.
   localparam int              CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0]   CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CW-1:0]   CNT_MAX  = '1;

   state_t        state, state_nxt;
   logic          prio, prio_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          err_addr_ld;
   logic          done;
   logic [31:0]   rdata_c;

   // Request of whichever master currently owns the bus.
   logic          sel_valid;
   logic          sel_write;
   logic [31:0]   sel_addr;
   logic [31:0]   sel_wdata;
   logic          timeout_hit;

   assign sel_valid = (state == BUSY1) ? m1_valid : m0_valid;
   assign sel_write = (state == BUSY1) ? m1_write : m0_write;
   assign sel_addr  = (state == BUSY1) ? m1_addr  : m0_addr;
   assign sel_wdata = (state == BUSY1) ? m1_wdata : m0_wdata;

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

   assign gnt = {state == BUSY1, state == BUSY0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         prio     <= 1'b0;
         cnt      <= '0;
         err_addr <= '0;
      end else begin
         state <= state_nxt;
         prio  <= prio_nxt;
         cnt   <= cnt_nxt;
         if (err_addr_ld) begin
            err_addr <= sel_addr;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      prio_nxt    = prio;
      cnt_nxt     = cnt;
      s_valid     = 1'b0;
      s_write     = 1'b0;
      s_addr      = '0;
      s_wdata     = '0;
      err_pulse   = 1'b0;
      err_addr_ld = 1'b0;
      done        = 1'b0;
      rdata_c     = '0;

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (m0_valid && m1_valid) begin
               state_nxt = prio ? BUSY1 : BUSY0;
            end else if (m0_valid) begin
               state_nxt = BUSY0;
            end else if (m1_valid) begin
               state_nxt = BUSY1;
            end
         end

         BUSY0, BUSY1: begin
            s_write = sel_write;
            s_addr  = sel_addr;
            s_wdata = sel_wdata;
            if (!sel_valid) begin
               // Master abandoned its request: release the bus silently, fairness untouched.
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (s_ready) begin
               // A slave completion in the timeout cycle still counts as a normal completion.
               s_valid = 1'b1;
               done    = 1'b1;
               rdata_c = s_rdata;
            end else if (timeout_hit) begin
               done        = 1'b1;
               rdata_c     = ERR_DATA;
               err_pulse   = 1'b1;
               err_addr_ld = 1'b1;
            end else begin
               s_valid = 1'b1;
               if (cnt != CNT_MAX) begin
                  cnt_nxt = cnt + 1'b1;
               end
            end

            if (done) begin
               state_nxt = IDLE;
               prio_nxt  = (state == BUSY0);
               cnt_nxt   = '0;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign m0_ready = done && (state == BUSY0);
   assign m1_ready = done && (state == BUSY1);
   assign m0_rdata = m0_ready ? rdata_c : '0;
   assign m1_rdata = m1_ready ? rdata_c : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Purpose: self-checking bench for bus_arbiter with a scoreboard of expected completions.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: a bench slave asserts s_ready in a programmable cycle of each grant (0 = never).
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_valid, m0_write, m1_valid, m1_write;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ready, m1_ready;
   logic        s_valid, s_write, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [1:0]  gnt;
   logic        err_pulse;
   logic [31:0] err_addr;

   int          n_chk = 0;
   int          n_err = 0;

   // Bench slave: answers in grant cycle slave_lat, returning slave_data ^ s_addr.
   int          slave_lat = 0;
   logic [31:0] slave_data = '0;
   int          busy_cyc = 0;

   typedef struct {
      logic        mst;
      logic [31:0] data;
      logic        err;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   bus_arbiter #(.TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .rst(rst),
      .m0_valid(m0_valid), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata), .m0_ready(m0_ready),
      .m1_valid(m1_valid), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata), .m1_ready(m1_ready),
      .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_ready(s_ready),
      .gnt(gnt), .err_pulse(err_pulse), .err_addr(err_addr)
   );

   // busy_cyc holds the number of grant cycles already elapsed before the current one.
   always @(posedge clk) begin
      busy_cyc <= (gnt != 2'b00) ? busy_cyc + 1 : 0;
   end

   assign s_ready = (slave_lat != 0) && (gnt != 2'b00) && (busy_cyc + 1 == slave_lat);
   assign s_rdata = slave_data ^ s_addr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input logic mst, input logic [31:0] data, input logic err);
      exp_t e;
      e.mst  = mst;
      e.data = data;
      e.err  = err;
      sb.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Completion monitor: every ready strobe must match the oldest expected completion.
   always @(negedge clk) begin
      exp_t e;
      if (m0_ready || m1_ready) begin
         chk("dual_ready", 32'(m0_ready & m1_ready), 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_ready", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("ready_master", 32'(m1_ready), 32'(e.mst));
            chk("rdata", m1_ready ? m1_rdata : m0_rdata, e.data);
            chk("err_pulse", 32'(err_pulse), 32'(e.err));
         end
      end else begin
         chk("err_without_ready", 32'(err_pulse), 32'd0);
      end
      if (!m0_ready) chk("m0_rdata_idle", m0_rdata, 32'd0);
      if (!m1_ready) chk("m1_rdata_idle", m1_rdata, 32'd0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      m0_valid = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_valid = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0;

      // Reset state
      cyc(); cyc(); smp();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_s_valid", 32'(s_valid), 32'd0);
      chk("rst_s_addr", s_addr, 32'd0);
      chk("rst_err_addr", err_addr, 32'd0);
      chk("rst_m0_ready", 32'(m0_ready), 32'd0);
      cyc(); rst = 1'b0;

      // Single m0 read, slave ready in its 3rd cycle
      cyc();
      m0_valid = 1'b1; m0_write = 1'b0; m0_addr = 32'h0000_0100;
      slave_lat = 3; slave_data = 32'h1234_5678 ^ 32'h0000_0100;
      push(1'b0, 32'h1234_5678, 1'b0);
      smp();
      chk("t1_sv_req_cycle", 32'(s_valid), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         cyc(); smp();
         chk("t1_s_valid", 32'(s_valid), 32'd1);
         chk("t1_gnt", 32'(gnt), 32'd1);
         chk("t1_s_addr", s_addr, 32'h0000_0100);
         chk("t1_m0_ready", 32'(m0_ready), 32'(k == 3));
      end
      cyc(); m0_valid = 1'b0; smp();
      chk("t1_gnt_after", 32'(gnt), 32'd0);
      chk("t1_sv_after", 32'(s_valid), 32'd0);

      // Both masters requesting from reset, zero-wait slave: alternating grants
      cyc(); rst = 1'b1;
      cyc(); rst = 1'b0;
      m0_valid = 1'b1; m0_addr = 32'h10;
      m1_valid = 1'b1; m1_addr = 32'h20; m1_write = 1'b0;
      slave_lat = 1; slave_data = 32'hA5A5_0000;
      push(1'b0, 32'hA5A5_0010, 1'b0);
      push(1'b1, 32'hA5A5_0020, 1'b0);
      push(1'b0, 32'hA5A5_0010, 1'b0);
      push(1'b1, 32'hA5A5_0020, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         logic [1:0] g;
         g = (k % 2 == 0) ? 2'b00 : ((k % 4 == 1) ? 2'b01 : 2'b10);
         cyc();
         if (k == 8) begin
            m0_valid = 1'b0; m1_valid = 1'b0;
         end
         smp();
         chk("t2_gnt", 32'(gnt), 32'(g));
         chk("t2_s_valid", 32'(s_valid), 32'(g != 2'b00));
      end

      // m1 write to a hung slave: forced error completion in the 8th cycle
      cyc();
      m1_valid = 1'b1; m1_write = 1'b1; m1_addr = 32'h8000_0010; m1_wdata = 32'hCAFE_F00D;
      slave_lat = 0;
      push(1'b1, 32'hDEAD_BEEF, 1'b1);
      smp();
      for (int k = 1; k <= 8; k++) begin
         cyc(); smp();
         chk("t3_s_valid", 32'(s_valid), 32'(k < 8));
         chk("t3_m1_ready", 32'(m1_ready), 32'(k == 8));
         if (k == 1) begin
            chk("t3_s_write", 32'(s_write), 32'd1);
            chk("t3_s_wdata", s_wdata, 32'hCAFE_F00D);
         end
      end
      cyc(); m1_valid = 1'b0; smp();
      chk("t3_err_addr", err_addr, 32'h8000_0010);
      chk("t3_gnt_after", 32'(gnt), 32'd0);

      // s_ready exactly in the timeout cycle wins
      cyc();
      m0_valid = 1'b1; m0_write = 1'b0; m0_addr = 32'h44;
      slave_lat = 8; slave_data = 32'h0BAD_0000;
      push(1'b0, 32'h0BAD_0044, 1'b0);
      smp();
      for (int k = 1; k <= 8; k++) begin
         cyc(); smp();
         chk("t4_s_valid", 32'(s_valid), 32'd1);
         chk("t4_m0_ready", 32'(m0_ready), 32'(k == 8));
      end
      cyc(); m0_valid = 1'b0; smp();
      chk("t4_err_addr_held", err_addr, 32'h8000_0010);

      // m0 drops its request mid-transaction; prio (now m1) must be unchanged
      cyc();
      m0_valid = 1'b1; m0_addr = 32'h48; slave_lat = 0;
      smp();
      cyc();
      m1_valid = 1'b1; m1_write = 1'b0; m1_addr = 32'h60;
      smp();
      chk("t5_gnt_m0", 32'(gnt), 32'd1);
      cyc(); smp();
      chk("t5_s_valid", 32'(s_valid), 32'd1);
      cyc(); m0_valid = 1'b0; smp();
      chk("t5_sv_dropped", 32'(s_valid), 32'd0);
      chk("t5_no_ready", 32'(m0_ready), 32'd0);
      cyc();
      m0_valid = 1'b1; slave_lat = 1; slave_data = 32'h5500_0000;
      push(1'b1, 32'h5500_0060, 1'b0);
      push(1'b0, 32'h5500_0048, 1'b0);
      smp();
      chk("t5_idle", 32'(gnt), 32'd0);
      cyc(); smp();
      chk("t5_gnt_m1", 32'(gnt), 32'd2);
      cyc(); m1_valid = 1'b0; smp();
      chk("t5_gap", 32'(gnt), 32'd0);
      cyc(); smp();
      chk("t5_gnt_m0_again", 32'(gnt), 32'd1);
      cyc(); m0_valid = 1'b0; smp();

      // Reset during BUSY1 with a stalled slave, then simultaneous request grants m0
      cyc();
      m1_valid = 1'b1; m1_addr = 32'h70; slave_lat = 0;
      smp();
      cyc(); smp();
      chk("t6_gnt_m1", 32'(gnt), 32'd2);
      cyc(); rst = 1'b1; smp();
      chk("t6_sv_before_rst", 32'(s_valid), 32'd1);
      cyc(); rst = 1'b0; m1_valid = 1'b0; smp();
      chk("t6_sv_after_rst", 32'(s_valid), 32'd0);
      chk("t6_gnt_after_rst", 32'(gnt), 32'd0);
      cyc();
      m0_valid = 1'b1; m0_addr = 32'h74;
      m1_valid = 1'b1; m1_addr = 32'h78;
      slave_lat = 1; slave_data = 32'h6600_0000;
      push(1'b0, 32'h6600_0074, 1'b0);
      push(1'b1, 32'h6600_0078, 1'b0);
      smp();
      cyc(); smp();
      chk("t6_gnt_m0_first", 32'(gnt), 32'd1);
      cyc(); m0_valid = 1'b0; smp();
      cyc(); smp();
      chk("t6_gnt_m1_next", 32'(gnt), 32'd2);
      cyc(); m1_valid = 1'b0; smp();
      cyc(); cyc(); smp();
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
